// File: rtl/uart_tx_block.sv
// UART transmitter: one-entry holding buffer, LSB-first framing with start/stop bits.
// Define UART_TX_PARITY_EN to add a parity_odd input and a parity bit before the stop bit.
module uart_tx_block #(
   parameter int BP_WIDTH = 14,
   parameter int DS_WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          tx_data,
   input  logic                data_load,
   input  logic                clear_error,
   input  logic [BP_WIDTH-1:0] bit_period,
   input  logic [DS_WIDTH-1:0] data_size,
`ifdef UART_TX_PARITY_EN
   input  logic                parity_odd,
`endif
   output logic                serial_out,
   output logic                buffer_full,
   output logic                tx_busy,
   output logic                tx_done,
   output logic                overrun_error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_e;

   state_e              state_q, state_d;
   logic [7:0]          buf_q, buf_d;
   logic                full_q, full_d;
   logic [7:0]          shift_q, shift_d;
   logic [BP_WIDTH-1:0] bp_q, bp_d;
   logic [DS_WIDTH-1:0] ds_q, ds_d;
   logic [BP_WIDTH-1:0] cnt_q, cnt_d;
   logic [DS_WIDTH-1:0] dcnt_q, dcnt_d;
   logic                ser_q, ser_d;
   logic                ovr_q, ovr_d;
`ifdef UART_TX_PARITY_EN
   logic                par_q, par_d;
   logic                odd_q, odd_d;
`endif

   logic                bit_end;
   logic                start_frame;
   logic [BP_WIDTH-1:0] bp_eff;
   logic [DS_WIDTH-1:0] ds_eff;

   assign bit_end = (cnt_q == bp_q - BP_WIDTH'(1));

   // The buffer is vacated whenever a frame is started from it.
   assign start_frame = full_q &&
                        ((state_q == S_IDLE) ||
                         ((state_q == S_STOP) && bit_end));

   assign bp_eff = (bit_period == '0) ? BP_WIDTH'(1) : bit_period;

   assign ds_eff = ((data_size >= DS_WIDTH'(5)) &&
                    (data_size <= DS_WIDTH'(8))) ?
                   data_size : DS_WIDTH'(8);

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      full_d  = full_q;
      shift_d = shift_q;
      bp_d    = bp_q;
      ds_d    = ds_q;
      cnt_d   = cnt_q;
      dcnt_d  = dcnt_q;
      ser_d   = ser_q;
      ovr_d   = ovr_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
      odd_d   = odd_q;
`endif

      if (start_frame) begin
         full_d = 1'b0;
      end
      if (clear_error) begin
         ovr_d = 1'b0;
      end
      if (data_load) begin
         if (!full_q || start_frame) begin
            buf_d  = tx_data;
            full_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end

      if (state_q == S_IDLE) begin
         cnt_d = '0;
      end else begin
         cnt_d = bit_end ? '0 : cnt_q + BP_WIDTH'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            ser_d = 1'b1;
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               ser_d   = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
`ifdef UART_TX_PARITY_EN
               par_d = par_q ^ shift_q[0];
`endif
               if (dcnt_q == ds_q - DS_WIDTH'(1)) begin
                  dcnt_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
                  ser_d   = par_q ^ shift_q[0] ^ odd_q;
`else
                  state_d = S_STOP;
                  ser_d   = 1'b1;
`endif
               end else begin
                  dcnt_d  = dcnt_q + DS_WIDTH'(1);
                  shift_d = shift_q >> 1;
                  ser_d   = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               ser_d   = 1'b1;
            end
         end
`endif
         S_STOP: begin
            ser_d = 1'b1;
            if (bit_end) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            ser_d   = 1'b1;
         end
      endcase

      // Frame start overrides the STOP->IDLE choice for gapless back-to-back.
      if (start_frame) begin
         state_d = S_START;
         shift_d = buf_q;
         bp_d    = bp_eff;
         ds_d    = ds_eff;
         cnt_d   = '0;
         dcnt_d  = '0;
         ser_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
         par_d   = 1'b0;
         odd_d   = parity_odd;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         buf_q   <= '0;
         full_q  <= 1'b0;
         shift_q <= '0;
         bp_q    <= '0;
         ds_q    <= '0;
         cnt_q   <= '0;
         dcnt_q  <= '0;
         ser_q   <= 1'b1;
         ovr_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
         odd_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         full_q  <= full_d;
         shift_q <= shift_d;
         bp_q    <= bp_d;
         ds_q    <= ds_d;
         cnt_q   <= cnt_d;
         dcnt_q  <= dcnt_d;
         ser_q   <= ser_d;
         ovr_q   <= ovr_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
         odd_q   <= odd_d;
`endif
      end
   end

   assign serial_out    = ser_q;
   assign buffer_full   = full_q;
   assign tx_busy       = (state_q != S_IDLE);
   assign tx_done       = (state_q == S_STOP) && bit_end;
   assign overrun_error = ovr_q;

endmodule

// File: tb/tb_uart_tx_block.sv
// Scoreboard bench for uart_tx_block: a line monitor decodes each frame
// and compares it with the expected byte/config queued at load time.
module tb_uart_tx_block;

`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  tx_data;
   logic        data_load;
   logic        clear_error;
   logic [13:0] bit_period;
   logic [3:0]  data_size;
`ifdef UART_TX_PARITY_EN
   logic        parity_odd;
`endif
   logic        serial_out;
   logic        buffer_full;
   logic        tx_busy;
   logic        tx_done;
   logic        overrun_error;

   uart_tx_block #(.BP_WIDTH(14), .DS_WIDTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .tx_data       (tx_data),
      .data_load     (data_load),
      .clear_error   (clear_error),
      .bit_period    (bit_period),
      .data_size     (data_size),
`ifdef UART_TX_PARITY_EN
      .parity_odd    (parity_odd),
`endif
      .serial_out    (serial_out),
      .buffer_full   (buffer_full),
      .tx_busy       (tx_busy),
      .tx_done       (tx_done),
      .overrun_error (overrun_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         bp;
      int         ds;
      bit         odd;
      bit         b2b;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
      end
   endtask

   function automatic int bp_eff(input int r);
      return (r == 0) ? 1 : r;
   endfunction

   function automatic int ds_eff(input int r);
      return (r >= 5 && r <= 8) ? r : 8;
   endfunction

   task automatic push(input logic [7:0] d, input int bpr, input int dsr,
                       input bit b2b);
      exp_t e;
      e.data = d;
      e.bp   = bp_eff(bpr);
      e.ds   = ds_eff(dsr);
`ifdef UART_TX_PARITY_EN
      e.odd  = parity_odd;
`else
      e.odd  = 1'b0;
`endif
      e.b2b  = b2b;
      exp_q.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge after the load edge.
   task automatic drive_load(input logic [7:0] d);
      tx_data   = d;
      data_load = 1'b1;
      @(negedge clk);
      data_load = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((tx_busy || buffer_full) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) chk("idle_timeout", 1, 0);
      repeat (2) @(negedge clk);
   endtask

   // Two loads overlap a frame (gapless), further loads exercise overrun.
   task automatic b2b_seq(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input int bpr, input int dsr);
      bit_period = 14'(bpr);
      data_size  = 4'(dsr);
      push(a, bpr, dsr, 1'b0);
      push(b, bpr, dsr, 1'b1);
      drive_load(a);
      @(negedge clk);
      drive_load(b);
      chk("full_before_ovr", buffer_full, 1);
      drive_load(c);
      chk("ovr_set", overrun_error, 1);
      tx_data     = c;
      data_load   = 1'b1;
      clear_error = 1'b1;
      @(negedge clk);
      data_load   = 1'b0;
      clear_error = 1'b0;
      chk("ovr_set_wins", overrun_error, 1);
      clear_error = 1'b1;
      @(negedge clk);
      clear_error = 1'b0;
      chk("ovr_clear", overrun_error, 0);
      wait_idle();
   endtask

   initial begin : monitor
      int   gap;
      int   n;
      int   bad;
      int   idx;
      bit   lvl;
      bit   aborted;
      exp_t e;
      gap = 0;
      forever begin
         @(negedge clk);
         if (rst || serial_out !== 1'b0) begin
            gap++;
            continue;
         end
         if (exp_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
            gap = 0;
            continue;
         end
         e = exp_q.pop_front();
         if (e.b2b) chk("b2b_gap", gap, 0);
         n       = (e.ds + 2 + PAR) * e.bp;
         bad     = 0;
         aborted = 1'b0;
         for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge clk);
            if (rst) begin
               aborted = 1'b1;
               break;
            end
            idx = c / e.bp;
            if (idx == 0) lvl = 1'b0;
            else if (idx <= e.ds) lvl = e.data[idx-1];
            else if (PAR == 1 && idx == e.ds + 1)
               lvl = ^(e.data & 8'((1 << e.ds) - 1)) ^ e.odd;
            else lvl = 1'b1;
            if (serial_out !== lvl) bad++;
            if (tx_busy !== 1'b1) bad++;
            if (tx_done !== (c == n - 1)) bad++;
         end
         if (!aborted)
            chk($sformatf("frame_%02h_bp%0d_ds%0d", e.data, e.bp, e.ds),
                bad, 0);
         gap = 0;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin : stim
      int bpr;
      int dsr;
      rst         = 1'b1;
      tx_data     = '0;
      data_load   = 1'b0;
      clear_error = 1'b0;
      bit_period  = 14'd10;
      data_size   = 4'd8;
`ifdef UART_TX_PARITY_EN
      parity_odd  = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_serial", serial_out, 1);
      chk("rst_full", buffer_full, 0);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_ovr", overrun_error, 0);
      rst = 1'b0;
      @(negedge clk);

      push(8'hD5, 10, 8, 1'b0);
      drive_load(8'hD5);
      chk("cap_full", buffer_full, 1);
      chk("cap_serial", serial_out, 1);
      @(negedge clk);
      chk("latency_start", serial_out, 0);
      chk("start_full", buffer_full, 0);
      repeat (20) @(negedge clk);
      bit_period = 14'd3;
      data_size  = 4'd5;
      wait_idle();
      chk("idle_serial", serial_out, 1);
      chk("idle_busy", tx_busy, 0);

      bit_period = 14'd10;
      data_size  = 4'd5;
      push(8'h15, 10, 5, 1'b0);
      drive_load(8'h15);
      wait_idle();

      b2b_seq(8'hA5, 8'h3C, 8'h99, 10, 8);

      bit_period = 14'd10;
      data_size  = 4'd8;
      push(8'hC3, 10, 8, 1'b0);
      drive_load(8'hC3);
      repeat (5) @(negedge clk);
      drive_load(8'h77);
      chk("mid_full", buffer_full, 1);
      repeat (38) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("async_serial", serial_out, 1);
      chk("async_full", buffer_full, 0);
      chk("async_busy", tx_busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      push(8'h5A, 10, 8, 1'b0);
      drive_load(8'h5A);
      wait_idle();

      for (int i = 0; i < 40; i++) begin
         bpr = int'($urandom_range(0, 4));
         dsr = int'($urandom_range(0, 15));
`ifdef UART_TX_PARITY_EN
         parity_odd = 1'($urandom_range(0, 1));
`endif
         if ($urandom_range(0, 2) == 0) begin
            b2b_seq(8'($urandom), 8'($urandom), 8'($urandom), bpr, dsr);
         end else begin
            bit_period = 14'(bpr);
            data_size  = 4'(dsr);
            push(8'($urandom), bpr, dsr, 1'b0);
            drive_load(exp_q[exp_q.size()-1].data);
            repeat (3) @(negedge clk);
            bit_period = 14'($urandom_range(0, 7));
            data_size  = 4'($urandom_range(0, 15));
`ifdef UART_TX_PARITY_EN
            parity_odd = ~parity_odd;
`endif
            wait_idle();
         end
      end

      repeat (5) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
